// File: rtl/fp_pkg.sv
// Shared types and sizing for the FP significand multiplier.
// FP_MUL_RADIX4_EN selects two multiplier bits retired per cycle instead of one.
package fp_pkg;
  localparam int MANT_W = 24;
  localparam int PROD_W = 2*MANT_W;
`ifdef FP_MUL_RADIX4_EN
  localparam int BITS_PER_STEP = 2;
`else
  localparam int BITS_PER_STEP = 1;
`endif
  localparam int STEPS = MANT_W/BITS_PER_STEP;
  localparam int CNT_W = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;
  typedef logic [MANT_W-1:0] mant_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/fp_mant_mul_seq_if.sv
// Operand/product handshake bundle for fp_mant_mul_seq.
interface fp_mant_mul_seq_if;
  import fp_pkg::*;
  logic  in_valid;
  logic  in_ready;
  mant_t a_mant;
  mant_t b_mant;
  logic  out_valid;
  logic  out_ready;
  prod_t product;
  logic  busy;

  modport master (
    output in_valid, a_mant, b_mant, out_ready,
    input  in_ready, out_valid, product, busy
  );
  modport slave (
    input  in_valid, a_mant, b_mant, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/fp_mul_step.sv
// One combinational shift-add step: add the selected partial product to the
// upper half, then shift {carry,acc,mplr} right. FP_MUL_RADIX4_EN: two bits/step.
module fp_mul_step
  import fp_pkg::*;
(
  input  mant_t             acc_i,
  input  mant_t             mplr_i,
  input  mant_t             mcand_i,
`ifdef FP_MUL_RADIX4_EN
  input  logic [MANT_W+1:0] mcand3_i,
`endif
  output mant_t             acc_o,
  output mant_t             mplr_o
);
`ifdef FP_MUL_RADIX4_EN
  logic [MANT_W+1:0] pp;
  logic [MANT_W+1:0] sum;

  always_comb begin
    pp = '0;
    case (mplr_i[1:0])
      2'd1:    pp = {2'b00, mcand_i};
      2'd2:    pp = {1'b0, mcand_i, 1'b0};
      2'd3:    pp = mcand3_i;
      default: pp = '0;
    endcase
  end

  // acc < 2^W and pp < 3*2^W, so sum fits W+2 bits and sum>>2 fits W bits.
  assign sum    = {2'b00, acc_i} + pp;
  assign acc_o  = sum[MANT_W+1:2];
  assign mplr_o = {sum[1:0], mplr_i[MANT_W-1:2]};
`else
  logic [MANT_W:0] sum;

  assign sum    = {1'b0, acc_i} + (mplr_i[0] ? {1'b0, mcand_i} : {(MANT_W+1){1'b0}});
  assign acc_o  = sum[MANT_W:1];
  assign mplr_o = {sum[0], mplr_i[MANT_W-1:1]};
`endif
endmodule

// File: rtl/fp_mant_mul_seq.sv
// Sequential 24x24 significand multiplier, one op in flight, valid/ready on both
// sides. FP_MUL_RADIX4_EN halves the iteration count (3x mcand built at accept).
module fp_mant_mul_seq
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fp_mant_mul_seq_if.slave   bus
);
  mul_state_t state_q, state_d;
  cnt_t       cnt_q,   cnt_d;
  mant_t      acc_q,   acc_d;
  mant_t      mplr_q,  mplr_d;
  mant_t      mcand_q, mcand_d;
  mant_t      acc_step, mplr_step;
`ifdef FP_MUL_RADIX4_EN
  logic [MANT_W+1:0] mcand3_q, mcand3_d;
`endif

  fp_mul_step u_step (
    .acc_i    (acc_q),
    .mplr_i   (mplr_q),
    .mcand_i  (mcand_q),
`ifdef FP_MUL_RADIX4_EN
    .mcand3_i (mcand3_q),
`endif
    .acc_o    (acc_step),
    .mplr_o   (mplr_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
`ifdef FP_MUL_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = MUL;
          cnt_d   = '0;
          acc_d   = '0;
          mplr_d  = bus.b_mant;
          mcand_d = bus.a_mant;
`ifdef FP_MUL_RADIX4_EN
          mcand3_d = {2'b00, bus.a_mant} + {1'b0, bus.a_mant, 1'b0};
`endif
        end
      end
      MUL: begin
        acc_d  = acc_step;
        mplr_d = mplr_step;
        cnt_d  = cnt_q + cnt_t'(1);
        // Last step still updates acc/mplr; product is {acc,mplr} from DONE on.
        if (cnt_q == cnt_t'(STEPS-1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      mcand_q  <= '0;
`ifdef FP_MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      mcand_q  <= mcand_d;
`ifdef FP_MUL_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.product   = {acc_q, mplr_q};
endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Scoreboard bench for fp_mant_mul_seq: stimulus pushes expected products,
// a negedge monitor checks latency, hold-under-backpressure and the product.
module tb_fp_mant_mul_seq;
  import fp_pkg::*;
`ifdef FP_MUL_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  fp_mant_mul_seq_if bus();

  fp_mant_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    prod_t p;
    int    acc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor
  logic  ov_prev = 1'b0;
  logic  or_prev = 1'b0;
  prod_t p_prev  = '0;
  int    last_out_hs = -100;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !ov_prev) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid actual=out_valid high required=no pending op");
        end else begin
          chk("latency", 64'(cyc - sbq[0].acc), 64'(LAT + 1));
        end
      end
      if (bus.out_valid && ov_prev && !or_prev)
        chk("hold_product", 64'(bus.product), 64'(p_prev));
      if (bus.out_valid && bus.out_ready && sbq.size() > 0) begin
        chk("product", 64'(bus.product), 64'(sbq[0].p));
        void'(sbq.pop_front());
        last_out_hs = cyc;
      end
    end
    ov_prev = bus.out_valid;
    or_prev = bus.out_ready;
    p_prev  = bus.product;
  end

  task automatic send(input mant_t a, input mant_t b, input prod_t expv, output int acc_at);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    bus.a_mant   = a;
    bus.b_mant   = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready low required=accept within 200 cycles");
      bus.in_valid = 1'b0;
      acc_at = -1;
      return;
    end
    e.p   = expv;
    e.acc = cyc;
    sbq.push_back(e);
    acc_at = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || bus.busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=%0d pending required=0 pending", sbq.size());
      sbq.delete();
    end
  endtask

  mant_t da [8] = '{24'h800000, 24'hFFFFFF, 24'hC00000, 24'h000000,
                    24'h800000, 24'h000001, 24'h123456, 24'h000003};
  mant_t db [8] = '{24'h800000, 24'hFFFFFF, 24'hC00000, 24'hABCDEF,
                    24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000005};
  prod_t dp [8] = '{48'h400000000000, 48'hFFFFFE000001, 48'h900000000000, 48'h000000000000,
                    48'h7FFFFF800000, 48'h000000FFFFFF, 48'h000000000000, 48'h00000000000F};

  initial begin
    int    acc1, acc2, n;
    mant_t ra, rb;

    bus.in_valid  = 1'b0;
    bus.a_mant    = '0;
    bus.b_mant    = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_product",   64'(bus.product),   64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      send(da[i], db[i], dp[i], acc1);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        chk("mul_busy",     64'(bus.busy),     64'd1);
        chk("mul_in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    wait_idle();

    // backpressure in DONE with stray operands offered
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(24'h800001, 24'h800001, 48'h400001000001, acc1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.a_mant   = 24'hFFFFFF;
    bus.b_mant   = 24'hFFFFFF;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("bp_stray_ignored", 64'(bus.busy), 64'd0);

    // reset in the middle of an operation
    send(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, acc1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy",      64'(bus.busy),      64'd0);
    chk("mid_rst_product",   64'(bus.product),   64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(24'h800000, 24'hC00000, 48'h600000000000, acc1);
    wait_idle();

    // back-to-back
    send(24'h400000, 24'h400000, 48'h100000000000, acc1);
    send(24'h7FFFFF, 24'h000002, 48'h000000FFFFFE, acc2);
    chk("b2b_accept", 64'(acc2), 64'(last_out_hs + 1));
    wait_idle();

    // random operands against a plain multiply
    for (int i = 0; i < 100; i++) begin
      ra = mant_t'($urandom);
      rb = mant_t'($urandom);
      if (i % 4 == 0) ra[MANT_W-1] = 1'b1;
      send(ra, rb, prod_t'(ra) * prod_t'(rb), acc1);
    end
    wait_idle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
